// File: rtl/fadd_sched.sv
// Round-robin scheduler sharing one pipelined fadd unit among NREQ requesters.
// Optional FADD_SCHED_SUB_EN adds req_sub_i so that a request can compute x1 - x2.
module fadd_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned FADD_LAT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [32*NREQ-1:0]   req_x1_i,
  input  logic [32*NREQ-1:0]   req_x2_i,
`ifdef FADD_SCHED_SUB_EN
  input  logic [NREQ-1:0]      req_sub_i,
`endif
  output logic [NREQ-1:0]      req_ready_o,
  output logic [31:0]          fadd_x1_o,
  output logic [31:0]          fadd_x2_o,
  input  logic [31:0]          fadd_y_i,
  output logic [NREQ-1:0]      resp_valid_o,
  output logic [31:0]          resp_y_o,
  output logic [3:0]           inflight_o
);

  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic                  grant_vld;
  logic [2:0]            grant_id;
  logic [2:0]            scan_idx;
  logic [7:0]            valid_pad;
  logic [7:0][31:0]      x1_arr, x2_arr;
  logic [31:0]           x1_sel, x2_sel;

  logic                  issue_vld_q;
  logic [2:0]            issue_id_q;
  logic [31:0]           fadd_x1_q, fadd_x2_q;

  logic [FADD_LAT-1:0]      tag_vld_q;
  logic [FADD_LAT-1:0][2:0] tag_id_q;
  logic                     tail_vld;
  logic [2:0]               tail_id;

  logic [NREQ-1:0]       resp_valid_q, resp_valid_d;
  logic [31:0]           resp_y_q;
  logic [3:0]            inflight_q, inflight_d;

  assign valid_pad = 8'(req_valid_i);
  assign x1_arr    = 256'(req_x1_i);
  assign x2_arr    = 256'(req_x2_i);

  // Scan upward from rr_ptr_q; reset forces an empty grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    if (!rst_i) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        scan_idx = 3'((32'(rr_ptr_q) + k) % NREQ);
        if (!grant_vld && valid_pad[scan_idx]) begin
          grant_vld = 1'b1;
          grant_id  = scan_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready_o[i] = grant_vld && (32'(grant_id) == i);
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = 3'((32'(grant_id) + 1) % NREQ);
    end
  end

  always_comb begin
    x1_sel = x1_arr[grant_id];
    x2_sel = x2_arr[grant_id];
`ifdef FADD_SCHED_SUB_EN
    if (8'(req_sub_i) >> grant_id != 8'd0 && ((8'(req_sub_i) >> grant_id) & 8'd1) == 8'd1) begin
      x2_sel[31] = ~x2_sel[31];
    end
`endif
  end

  assign tail_vld = tag_vld_q[FADD_LAT-1];
  assign tail_id  = tag_id_q[FADD_LAT-1];

  always_comb begin
    resp_valid_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      resp_valid_d[i] = tail_vld && (32'(tail_id) == i);
    end
  end

  // A response is counted as retired at the edge that ends its resp_valid cycle.
  assign inflight_d = inflight_q + 4'(grant_vld) - 4'(|resp_valid_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      issue_vld_q  <= 1'b0;
      issue_id_q   <= '0;
      fadd_x1_q    <= '0;
      fadd_x2_q    <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= '0;
      resp_y_q     <= '0;
      inflight_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      issue_vld_q <= grant_vld;
      if (grant_vld) begin
        issue_id_q <= grant_id;
        fadd_x1_q  <= x1_sel;
        fadd_x2_q  <= x2_sel;
      end
      tag_vld_q[0] <= issue_vld_q;
      tag_id_q[0]  <= issue_id_q;
      for (int unsigned i = 1; i < FADD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      resp_valid_q <= resp_valid_d;
      if (tail_vld) begin
        resp_y_q <= fadd_y_i;
      end
      inflight_q <= inflight_d;
    end
  end

  assign fadd_x1_o    = fadd_x1_q;
  assign fadd_x2_o    = fadd_x2_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_y_o     = resp_y_q;
  assign inflight_o   = inflight_q;

endmodule
